// File: rtl/stage_ex_muldiv_if.sv
// ============================================================================
// Module      : stage_ex_muldiv_if
// Description : ID->EX->MM bundle for the execute stage with RV32M unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stage_ex_muldiv_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_SRC_W  = 2,
  parameter int FFW_N      = 2
);
  logic                         en;
  logic                         stall;
  logic                         flush;
  logic [DATA_W-1:0]            pc;
  logic                         is_load;
  logic                         is_store;
  logic                         is_atomic;
  logic                         reg_wr;
  logic [REG_ADDR_W-1:0]        reg_addr_rd;
  logic [REG_ADDR_W-1:0]        reg_addr_r1;
  logic [REG_ADDR_W-1:0]        reg_addr_r2;
  logic [3:0]                   alu_op;
  logic [ALU_SRC_W-1:0]         alu_src_arg1;
  logic [ALU_SRC_W-1:0]         alu_src_arg2;
  logic [DATA_W-1:0]            imm;
  logic [DATA_W-1:0]            reg_data_r1;
  logic [DATA_W-1:0]            reg_data_r2;
  logic                         is_jump;
  logic                         is_branch;
  logic [2:0]                   branch_type;
  logic                         is_muldiv;
  logic [2:0]                   muldiv_op;
  logic [FFW_N-1:0]             ffw_reg_wr;
  logic [FFW_N*REG_ADDR_W-1:0]  ffw_reg_addr_rd;
  logic [FFW_N*DATA_W-1:0]      ffw_reg_data_rd;

  logic                         jump;
  logic [DATA_W-1:0]            jump_addr;
  logic [DATA_W-1:0]            mem_addr;
  logic                         busy;
  logic                         out_reg_wr;
  logic                         out_is_load;
  logic                         out_is_store;
  logic                         out_is_atomic;
  logic                         out_flush;
  logic [REG_ADDR_W-1:0]        out_reg_addr_rd;
  logic [DATA_W-1:0]            out_reg_data_rd;
  logic [DATA_W-1:0]            out_alu_mem_addr;

  modport master (
    output en, stall, flush, pc, is_load, is_store, is_atomic, reg_wr,
           reg_addr_rd, reg_addr_r1, reg_addr_r2, alu_op, alu_src_arg1,
           alu_src_arg2, imm, reg_data_r1, reg_data_r2, is_jump, is_branch,
           branch_type, is_muldiv, muldiv_op, ffw_reg_wr, ffw_reg_addr_rd,
           ffw_reg_data_rd,
    input  jump, jump_addr, mem_addr, busy, out_reg_wr, out_is_load,
           out_is_store, out_is_atomic, out_flush, out_reg_addr_rd,
           out_reg_data_rd, out_alu_mem_addr
  );

  modport slave (
    input  en, stall, flush, pc, is_load, is_store, is_atomic, reg_wr,
           reg_addr_rd, reg_addr_r1, reg_addr_r2, alu_op, alu_src_arg1,
           alu_src_arg2, imm, reg_data_r1, reg_data_r2, is_jump, is_branch,
           branch_type, is_muldiv, muldiv_op, ffw_reg_wr, ffw_reg_addr_rd,
           ffw_reg_data_rd,
    output jump, jump_addr, mem_addr, busy, out_reg_wr, out_is_load,
           out_is_store, out_is_atomic, out_flush, out_reg_addr_rd,
           out_reg_data_rd, out_alu_mem_addr
  );
endinterface

`default_nettype wire

// File: rtl/stage_ex_muldiv.sv
// ============================================================================
// Module      : stage_ex_muldiv
// Description : Execute stage - ALU, branch resolution, N-channel forwarding,
//               iterative RV32M multiply/divide and EX/MM pipeline registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stage_ex_muldiv #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_SRC_W  = 2,
  parameter int FFW_N      = 2
) (
  input  wire logic        clk,
  input  wire logic        rst,
  stage_ex_muldiv_if.slave bus
);

  localparam int c_SHW   = $clog2(DATA_W);
  localparam int c_CNT_W = $clog2(DATA_W);

  localparam logic [ALU_SRC_W-1:0] c_SRC_REG = ALU_SRC_W'(0);
  localparam logic [ALU_SRC_W-1:0] c_SRC_IMM = ALU_SRC_W'(1);
  localparam logic [ALU_SRC_W-1:0] c_SRC_PC  = ALU_SRC_W'(2);

  localparam logic [3:0] c_ALU_ADD  = 4'd0;
  localparam logic [3:0] c_ALU_SUB  = 4'd1;
  localparam logic [3:0] c_ALU_SLL  = 4'd2;
  localparam logic [3:0] c_ALU_SLT  = 4'd3;
  localparam logic [3:0] c_ALU_SLTU = 4'd4;
  localparam logic [3:0] c_ALU_XOR  = 4'd5;
  localparam logic [3:0] c_ALU_SRL  = 4'd6;
  localparam logic [3:0] c_ALU_SRA  = 4'd7;
  localparam logic [3:0] c_ALU_OR   = 4'd8;
  localparam logic [3:0] c_ALU_AND  = 4'd9;
  localparam logic [3:0] c_ALU_PASS = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [c_CNT_W-1:0]      r_cnt;
  logic [2:0]              r_op;
  logic [REG_ADDR_W-1:0]   r_rd;
  logic [DATA_W-1:0]       r_a;
  logic [DATA_W-1:0]       r_bmag;
  logic                    r_neg_a;
  logic                    r_neg_b;
  logic [2*DATA_W-1:0]     r_acc;

  logic                    r_out_reg_wr;
  logic                    r_out_is_load;
  logic                    r_out_is_store;
  logic                    r_out_is_atomic;
  logic                    r_out_flush;
  logic [REG_ADDR_W-1:0]   r_out_reg_addr_rd;
  logic [DATA_W-1:0]       r_out_reg_data_rd;
  logic [DATA_W-1:0]       r_out_alu_mem_addr;

  logic [DATA_W-1:0]       w_r1_fwd;
  logic [DATA_W-1:0]       w_r2_fwd;
  logic [DATA_W-1:0]       w_arg1;
  logic [DATA_W-1:0]       w_arg2;
  logic [DATA_W-1:0]       w_alu_res;
  logic                    w_br_cond;
  logic                    w_start;
  logic                    w_bubble_cond;
  logic                    w_load_bubble;
  logic                    w_load_instr;
  logic                    w_a_signed;
  logic                    w_b_signed;
  logic                    w_neg_a_in;
  logic                    w_neg_b_in;
  logic [DATA_W:0]         w_mul_sum;
  logic [DATA_W:0]         w_div_rs;
  logic                    w_div_ge;
  logic [DATA_W-1:0]       w_div_diff;
  logic [2*DATA_W-1:0]     w_acc_nxt;
  logic [2*DATA_W-1:0]     w_prod;
  logic [DATA_W-1:0]       w_quo;
  logic [DATA_W-1:0]       w_rem;
  logic [DATA_W-1:0]       w_md_result;
  logic [DATA_W-1:0]       w_data_to_wr;

  // Forwarding: walk from highest to lowest channel so channel 0 wins.
  always_comb begin
    w_r1_fwd = bus.reg_data_r1;
    w_r2_fwd = bus.reg_data_r2;
    for (int i = FFW_N - 1; i >= 0; i--) begin
      if (bus.ffw_reg_wr[i] && (bus.reg_addr_r1 != '0) &&
          (bus.ffw_reg_addr_rd[i*REG_ADDR_W +: REG_ADDR_W] == bus.reg_addr_r1))
        w_r1_fwd = bus.ffw_reg_data_rd[i*DATA_W +: DATA_W];
      if (bus.ffw_reg_wr[i] && (bus.reg_addr_r2 != '0) &&
          (bus.ffw_reg_addr_rd[i*REG_ADDR_W +: REG_ADDR_W] == bus.reg_addr_r2))
        w_r2_fwd = bus.ffw_reg_data_rd[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    case (bus.alu_src_arg1)
      c_SRC_REG: w_arg1 = w_r1_fwd;
      c_SRC_IMM: w_arg1 = bus.imm;
      c_SRC_PC:  w_arg1 = bus.pc;
      default:   w_arg1 = '0;
    endcase
    case (bus.alu_src_arg2)
      c_SRC_REG: w_arg2 = w_r2_fwd;
      c_SRC_IMM: w_arg2 = bus.imm;
      c_SRC_PC:  w_arg2 = bus.pc;
      default:   w_arg2 = '0;
    endcase
  end

  always_comb begin
    case (bus.alu_op)
      c_ALU_ADD:  w_alu_res = w_arg1 + w_arg2;
      c_ALU_SUB:  w_alu_res = w_arg1 - w_arg2;
      c_ALU_SLL:  w_alu_res = w_arg1 << w_arg2[c_SHW-1:0];
      c_ALU_SLT:  w_alu_res = {{(DATA_W-1){1'b0}}, $signed(w_arg1) < $signed(w_arg2)};
      c_ALU_SLTU: w_alu_res = {{(DATA_W-1){1'b0}}, w_arg1 < w_arg2};
      c_ALU_XOR:  w_alu_res = w_arg1 ^ w_arg2;
      c_ALU_SRL:  w_alu_res = w_arg1 >> w_arg2[c_SHW-1:0];
      c_ALU_SRA:  w_alu_res = $unsigned($signed(w_arg1) >>> w_arg2[c_SHW-1:0]);
      c_ALU_OR:   w_alu_res = w_arg1 | w_arg2;
      c_ALU_AND:  w_alu_res = w_arg1 & w_arg2;
      c_ALU_PASS: w_alu_res = w_arg2;
      default:    w_alu_res = '0;
    endcase
  end

  // Branch conditions always compare the forwarded register operands.
  always_comb begin
    case (bus.branch_type)
      3'b000:  w_br_cond = (w_r1_fwd == w_r2_fwd);
      3'b001:  w_br_cond = (w_r1_fwd != w_r2_fwd);
      3'b100:  w_br_cond = ($signed(w_r1_fwd) <  $signed(w_r2_fwd));
      3'b101:  w_br_cond = ($signed(w_r1_fwd) >= $signed(w_r2_fwd));
      3'b110:  w_br_cond = (w_r1_fwd <  w_r2_fwd);
      3'b111:  w_br_cond = (w_r1_fwd >= w_r2_fwd);
      default: w_br_cond = 1'b0;
    endcase
  end

  assign bus.jump      = (bus.is_jump | (bus.is_branch & w_br_cond)) & ~bus.flush & ~bus.is_muldiv;
  assign bus.jump_addr = w_alu_res;
  assign bus.mem_addr  = w_alu_res;

  assign w_start = (r_state == ST_IDLE) & bus.en & bus.is_muldiv & ~bus.flush;
  assign bus.busy = ~rst & (w_start | (r_state == ST_RUN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (bus.flush)                            w_state_nxt = ST_IDLE;
        else if (r_cnt == c_CNT_W'(DATA_W - 1))   w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (bus.flush || (bus.en && !bus.stall))  w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // MUL/MULH/MULHSU treat rs1 as signed; MULHSU leaves rs2 unsigned.
  assign w_a_signed = (bus.muldiv_op == 3'b000) | (bus.muldiv_op == 3'b001) |
                      (bus.muldiv_op == 3'b010) | (bus.muldiv_op == 3'b100) |
                      (bus.muldiv_op == 3'b110);
  assign w_b_signed = (bus.muldiv_op == 3'b000) | (bus.muldiv_op == 3'b001) |
                      (bus.muldiv_op == 3'b100) | (bus.muldiv_op == 3'b110);
  assign w_neg_a_in = w_a_signed & w_r1_fwd[DATA_W-1];
  assign w_neg_b_in = w_b_signed & w_r2_fwd[DATA_W-1];

  // Low half of the accumulator holds the multiplier or the dividend.
  assign w_mul_sum  = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_bmag} : '0);
  assign w_div_rs   = {r_acc[2*DATA_W-1:DATA_W], r_acc[DATA_W-1]};
  assign w_div_ge   = (w_div_rs >= {1'b0, r_bmag});
  assign w_div_diff = w_div_rs[DATA_W-1:0] - r_bmag;
  assign w_acc_nxt  = r_op[2] ?
                      {(w_div_ge ? w_div_diff : w_div_rs[DATA_W-1:0]), r_acc[DATA_W-2:0], w_div_ge} :
                      {w_mul_sum, r_acc[DATA_W-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_op    <= '0;
      r_rd    <= '0;
      r_a     <= '0;
      r_bmag  <= '0;
      r_neg_a <= 1'b0;
      r_neg_b <= 1'b0;
      r_acc   <= '0;
    end else if (w_start) begin
      r_cnt   <= '0;
      r_op    <= bus.muldiv_op;
      r_rd    <= bus.reg_addr_rd;
      r_a     <= w_r1_fwd;
      r_bmag  <= w_neg_b_in ? -w_r2_fwd : w_r2_fwd;
      r_neg_a <= w_neg_a_in;
      r_neg_b <= w_neg_b_in;
      r_acc   <= {{DATA_W{1'b0}}, (w_neg_a_in ? -w_r1_fwd : w_r1_fwd)};
    end else if (r_state == ST_RUN) begin
      r_cnt   <= r_cnt + 1'b1;
      r_acc   <= w_acc_nxt;
    end
  end

  assign w_prod = (r_neg_a ^ r_neg_b) ? -r_acc : r_acc;

  // Divide-by-zero bypasses sign correction; signed overflow falls out naturally.
  always_comb begin
    if (r_bmag == '0) begin
      w_quo = '1;
      w_rem = r_a;
    end else begin
      w_quo = (r_neg_a ^ r_neg_b) ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
      w_rem = r_neg_a ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];
    end
    if (r_op[2])              w_md_result = r_op[1] ? w_rem : w_quo;
    else if (r_op == 3'b000)  w_md_result = w_prod[DATA_W-1:0];
    else                      w_md_result = w_prod[2*DATA_W-1:DATA_W];
  end

  always_comb begin
    if (r_state == ST_DONE)  w_data_to_wr = w_md_result;
    else if (bus.is_jump)    w_data_to_wr = bus.pc + DATA_W'(4);
    else if (bus.is_store)   w_data_to_wr = w_r2_fwd;
    else                     w_data_to_wr = w_alu_res;
  end

  assign w_bubble_cond = w_start | (r_state == ST_RUN) | ((r_state == ST_DONE) & bus.flush);
  assign w_load_bubble = ~bus.stall & w_bubble_cond;
  assign w_load_instr  = ~bus.stall & bus.en & ~w_bubble_cond;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_reg_wr       <= 1'b0;
      r_out_is_load      <= 1'b0;
      r_out_is_store     <= 1'b0;
      r_out_is_atomic    <= 1'b0;
      r_out_flush        <= 1'b1;
      r_out_reg_addr_rd  <= '0;
      r_out_reg_data_rd  <= '0;
      r_out_alu_mem_addr <= '0;
    end else if (w_load_bubble) begin
      r_out_reg_wr       <= 1'b0;
      r_out_is_load      <= 1'b0;
      r_out_is_store     <= 1'b0;
      r_out_is_atomic    <= bus.is_atomic;
      r_out_flush        <= 1'b1;
    end else if (w_load_instr) begin
      r_out_reg_wr       <= bus.reg_wr & ~bus.flush;
      r_out_is_load      <= bus.is_load & ~bus.flush;
      r_out_is_store     <= bus.is_store & ~bus.flush;
      r_out_is_atomic    <= bus.is_atomic;
      r_out_flush        <= bus.flush;
      r_out_reg_addr_rd  <= (r_state == ST_DONE) ? r_rd : bus.reg_addr_rd;
      r_out_reg_data_rd  <= w_data_to_wr;
      r_out_alu_mem_addr <= w_alu_res;
    end
  end

  assign bus.out_reg_wr       = r_out_reg_wr;
  assign bus.out_is_load      = r_out_is_load;
  assign bus.out_is_store     = r_out_is_store;
  assign bus.out_is_atomic    = r_out_is_atomic;
  assign bus.out_flush        = r_out_flush;
  assign bus.out_reg_addr_rd  = r_out_reg_addr_rd;
  assign bus.out_reg_data_rd  = r_out_reg_data_rd;
  assign bus.out_alu_mem_addr = r_out_alu_mem_addr;

endmodule

`default_nettype wire

// File: tb/tb_stage_ex_muldiv.sv
// ============================================================================
// Module      : tb_stage_ex_muldiv
// Description : Directed self-checking bench for stage_ex_muldiv.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stage_ex_muldiv;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int SW = 2;
  localparam int FN = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  stage_ex_muldiv_if #(.DATA_W(DW), .REG_ADDR_W(AW), .ALU_SRC_W(SW), .FFW_N(FN)) bus ();

  stage_ex_muldiv #(.DATA_W(DW), .REG_ADDR_W(AW), .ALU_SRC_W(SW), .FFW_N(FN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input logic [AW-1:0] rd, input logic [DW-1:0] data);
    exp_t e;
    e.rd   = rd;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    chk({tag, " sb_depth"}, DW'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, " data"}, bus.out_reg_data_rd, e.data);
      chk({tag, " rd"}, DW'(bus.out_reg_addr_rd), DW'(e.rd));
      chk({tag, " wr"}, DW'(bus.out_reg_wr), 32'd1);
    end
  endtask

  task automatic set_idle();
    bus.en = 1'b1;            bus.stall = 1'b0;         bus.flush = 1'b0;
    bus.pc = '0;              bus.is_load = 1'b0;       bus.is_store = 1'b0;
    bus.is_atomic = 1'b0;     bus.reg_wr = 1'b0;        bus.reg_addr_rd = '0;
    bus.reg_addr_r1 = '0;     bus.reg_addr_r2 = '0;     bus.alu_op = 4'd0;
    bus.alu_src_arg1 = '0;    bus.alu_src_arg2 = '0;    bus.imm = '0;
    bus.reg_data_r1 = '0;     bus.reg_data_r2 = '0;     bus.is_jump = 1'b0;
    bus.is_branch = 1'b0;     bus.branch_type = 3'd0;   bus.is_muldiv = 1'b0;
    bus.muldiv_op = 3'd0;     bus.ffw_reg_wr = '0;      bus.ffw_reg_addr_rd = '0;
    bus.ffw_reg_data_rd = '0;
  endtask

  task automatic drive_md(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [AW-1:0] rd);
    set_idle();
    bus.is_muldiv   = 1'b1;
    bus.muldiv_op   = op;
    bus.reg_wr      = 1'b1;
    bus.reg_addr_rd = rd;
    bus.reg_addr_r1 = 5'd1;
    bus.reg_addr_r2 = 5'd2;
    bus.reg_data_r1 = a;
    bus.reg_data_r2 = b;
  endtask

  task automatic run_md(input string tag, input logic [2:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [AW-1:0] rd,
                        input logic [DW-1:0] exp, input bit stall_done);
    int cnt;
    drive_md(op, a, b, rd);
    sb_push(rd, exp);
    #1;
    cnt = 0;
    while (bus.busy && cnt < 100) begin
      cnt++;
      step();
    end
    chk({tag, " busy_cycles"}, DW'(cnt), DW'(DW + 1));
    chk({tag, " bubble_flush"}, DW'(bus.out_flush), 32'd1);
    if (stall_done) begin
      bus.stall = 1'b1;
      repeat (3) step();
      chk({tag, " stall_busy"}, DW'(bus.busy), 32'd0);
      chk({tag, " stall_hold_wr"}, DW'(bus.out_reg_wr), 32'd0);
      bus.stall = 1'b0;
    end
    step();
    sb_check(tag);
    set_idle();
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    rst = 1'b1;
    repeat (2) step();
    chk("rst out_flush", DW'(bus.out_flush), 32'd1);
    chk("rst out_reg_wr", DW'(bus.out_reg_wr), 32'd0);
    chk("rst out_data", bus.out_reg_data_rd, 32'd0);
    chk("rst out_rd", DW'(bus.out_reg_addr_rd), 32'd0);
    chk("rst busy", DW'(bus.busy), 32'd0);
    rst = 1'b0;
    step();

    run_md("MUL 7*-3",         3'b000, 32'd7,         32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 1'b0);
    run_md("MULHU ff*ff",      3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE, 1'b0);
    run_md("MULH -1*-1",       3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'h0000_0000, 1'b0);
    run_md("MULHSU -1*ff",     3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFF, 1'b0);
    run_md("DIV ovf",          3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7,  32'h8000_0000, 1'b0);
    run_md("REM ovf",          3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  32'h0000_0000, 1'b0);
    run_md("DIVU 123/0",       3'b101, 32'd123,       32'd0,         5'd9,  32'hFFFF_FFFF, 1'b0);
    run_md("REMU 123/0",       3'b111, 32'd123,       32'd0,         5'd10, 32'd123,       1'b0);
    run_md("DIV -7/2",         3'b100, 32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFD, 1'b0);
    run_md("REM -7/2",         3'b110, 32'hFFFF_FFF9, 32'd2,         5'd12, 32'hFFFF_FFFF, 1'b0);
    run_md("MUL stall 6*7",    3'b000, 32'd6,         32'd7,         5'd13, 32'd42,        1'b1);

    // Forwarding priority: channel 0 beats channel 1 on the same rd.
    set_idle();
    bus.reg_wr = 1'b1;  bus.reg_addr_rd = 5'd7;
    bus.alu_op = 4'd0;  bus.alu_src_arg1 = 2'd0;  bus.alu_src_arg2 = 2'd1;  bus.imm = 32'd1;
    bus.reg_addr_r1 = 5'd5;  bus.reg_data_r1 = 32'h99;
    bus.ffw_reg_wr = 2'b11;
    bus.ffw_reg_addr_rd = {5'd5, 5'd5};
    bus.ffw_reg_data_rd = {32'h22, 32'h11};
    #1;
    chk("fwd ch0 mem_addr", bus.mem_addr, 32'h12);
    sb_push(5'd7, 32'h12);
    step();
    sb_check("fwd ch0");

    bus.ffw_reg_wr = 2'b10;
    #1;
    sb_push(5'd7, 32'h23);
    step();
    sb_check("fwd ch1");

    bus.reg_addr_r1 = 5'd0;  bus.reg_data_r1 = 32'd9;
    bus.ffw_reg_wr = 2'b11;  bus.ffw_reg_addr_rd = {5'd0, 5'd0};
    #1;
    sb_push(5'd7, 32'd10);
    step();
    sb_check("fwd r0");

    // SUB with both operands from registers, rs2 forwarded on channel 1.
    set_idle();
    bus.reg_wr = 1'b1;  bus.reg_addr_rd = 5'd8;  bus.alu_op = 4'd1;
    bus.reg_addr_r1 = 5'd3;  bus.reg_data_r1 = 32'h30;
    bus.reg_addr_r2 = 5'd4;  bus.reg_data_r2 = 32'h77;
    bus.ffw_reg_wr = 2'b10;  bus.ffw_reg_addr_rd = {5'd4, 5'd4};
    bus.ffw_reg_data_rd = {32'h10, 32'h55};
    #1;
    sb_push(5'd8, 32'h20);
    step();
    sb_check("sub fwd r2");

    // JAL-style: target pc+imm, link pc+4.
    set_idle();
    bus.is_jump = 1'b1;  bus.reg_wr = 1'b1;  bus.reg_addr_rd = 5'd1;
    bus.pc = 32'h100;    bus.imm = 32'h20;
    bus.alu_src_arg1 = 2'd2;  bus.alu_src_arg2 = 2'd1;
    #1;
    chk("jal jump", DW'(bus.jump), 32'd1);
    chk("jal jump_addr", bus.jump_addr, 32'h120);
    sb_push(5'd1, 32'h104);
    step();
    sb_check("jal link");

    set_idle();
    bus.is_branch = 1'b1;  bus.branch_type = 3'b000;
    bus.reg_data_r1 = 32'd5;  bus.reg_data_r2 = 32'd5;
    bus.flush = 1'b1;
    #1;
    chk("beq flushed", DW'(bus.jump), 32'd0);
    bus.flush = 1'b0;
    #1;
    chk("beq taken", DW'(bus.jump), 32'd1);
    bus.branch_type = 3'b001;
    #1;
    chk("bne equal", DW'(bus.jump), 32'd0);
    bus.reg_data_r1 = 32'hFFFF_FFFF;  bus.reg_data_r2 = 32'd1;  bus.branch_type = 3'b100;
    #1;
    chk("blt signed", DW'(bus.jump), 32'd1);
    bus.branch_type = 3'b110;
    #1;
    chk("bltu unsigned", DW'(bus.jump), 32'd0);
    set_idle();
    step();

    // Flush during RUN aborts without writing a result.
    drive_md(3'b100, 32'd50, 32'd5, 5'd14);
    #1;
    step();
    repeat (4) step();
    bus.flush = 1'b1;
    #1;
    chk("abort busy_before", DW'(bus.busy), 32'd1);
    step();
    chk("abort busy_after", DW'(bus.busy), 32'd0);
    chk("abort out_reg_wr", DW'(bus.out_reg_wr), 32'd0);
    chk("abort out_flush", DW'(bus.out_flush), 32'd1);
    set_idle();
    step();

    // Asynchronous reset at RUN iteration 10, inputs still presenting muldiv.
    drive_md(3'b101, 32'd100, 32'd7, 5'd15);
    #1;
    step();
    repeat (10) step();
    chk("pre-rst busy", DW'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid-rst busy", DW'(bus.busy), 32'd0);
    chk("mid-rst out_flush", DW'(bus.out_flush), 32'd1);
    chk("mid-rst out_reg_wr", DW'(bus.out_reg_wr), 32'd0);
    chk("mid-rst out_data", bus.out_reg_data_rd, 32'd0);
    set_idle();
    step();
    rst = 1'b0;
    step();
    run_md("DIVU 100/7", 3'b101, 32'd100, 32'd7, 5'd16, 32'd14, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
